// File: rtl/adder_arb_pkg.sv
// Shared definitions for the adder arbiter: data width, FSM encoding and
// the round-robin pick function used by adder_arb_rr.
package adder_arb_pkg;

  localparam int DATA_W  = 32;
  localparam int MAX_REQ = 8;
  localparam int IDX_W   = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } rr_pick_t;

  // Search upward from last+1 with wrap; bits at or above num are zero-padded by the caller.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                       input logic [IDX_W-1:0]   last,
                                       input int                 num);
    rr_pick_t         r;
    logic [IDX_W-1:0] cand;
    r.found = 1'b0;
    r.idx   = 3'd0;
    for (int off = 1; off <= MAX_REQ; off++) begin
      cand = IDX_W'((int'(last) + off) % num);
      if (!r.found && valid[cand]) begin
        r.found = 1'b1;
        r.idx   = cand;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/HybridAdder.sv
// 32-bit adder built as a ripple of eight 4-bit carry-lookahead blocks.
module HybridAdder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        c_in,
  output logic [31:0] sum,
  output logic        c_out
);

  logic [8:0] carry_s;

  assign carry_s[0] = c_in;
  assign c_out      = carry_s[8];

  for (genvar g = 0; g < 8; g++) begin : g_blk
    logic [3:0] p_s;
    logic [3:0] gen_s;
    logic [4:0] c_s;

    assign p_s   = a[4*g +: 4] ^ b[4*g +: 4];
    assign gen_s = a[4*g +: 4] & b[4*g +: 4];
    assign c_s[0] = carry_s[g];
    assign c_s[1] = gen_s[0] | (p_s[0] & c_s[0]);
    assign c_s[2] = gen_s[1] | (p_s[1] & gen_s[0]) | (p_s[1] & p_s[0] & c_s[0]);
    assign c_s[3] = gen_s[2] | (p_s[2] & gen_s[1]) | (p_s[2] & p_s[1] & gen_s[0])
                  | (p_s[2] & p_s[1] & p_s[0] & c_s[0]);
    assign c_s[4] = gen_s[3] | (p_s[3] & gen_s[2]) | (p_s[3] & p_s[2] & gen_s[1])
                  | (p_s[3] & p_s[2] & p_s[1] & gen_s[0])
                  | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & c_s[0]);
    assign sum[4*g +: 4] = p_s ^ c_s[3:0];
    assign carry_s[g+1]  = c_s[4];
  end

endmodule

// File: rtl/adder_arb_rr.sv
// Combinational round-robin picker: one-hot grant plus winner index.
module adder_arb_rr
  import adder_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] grant,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  logic [MAX_REQ-1:0] valid_pad_s;
  rr_pick_t           pick_s;

  assign valid_pad_s = MAX_REQ'(valid);

  // Winner selection and one-hot expansion.
  always_comb begin
    pick_s = rr_pick(valid_pad_s, last, NUM_REQ);
    found  = pick_s.found;
    idx    = pick_s.idx;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant[i] = pick_s.found && (pick_s.idx == IDX_W'(i));
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin shared 32-bit adder with grant/execute/respond sequencing.
// Optional signed-overflow output enabled by defining ADDER_ARB_OVF_EN.
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ-1:0]        req_sub,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_W-1:0]         rsp_sum,
  output logic                      rsp_cout,
  output logic [ID_W-1:0]           rsp_id
`ifdef ADDER_ARB_OVF_EN
  ,output logic                     rsp_ovf
`endif
);

  state_t             state_r;
  logic [IDX_W-1:0]   last_grant_r;
  logic [DATA_W-1:0]  op_a_r;
  logic [DATA_W-1:0]  op_b_r;
  logic               op_cin_r;
  logic [ID_W-1:0]    id_r;
  logic               rsp_valid_r;
  logic [DATA_W-1:0]  rsp_sum_r;
  logic               rsp_cout_r;
  logic [ID_W-1:0]    rsp_id_r;

  logic [NUM_REQ-1:0] grant_s;
  logic               found_s;
  logic [IDX_W-1:0]   idx_s;
  logic [DATA_W-1:0]  sel_a_s;
  logic [DATA_W-1:0]  sel_b_s;
  logic               sel_sub_s;
  logic [DATA_W-1:0]  sum_s;
  logic               cout_s;

  adder_arb_rr #(.NUM_REQ(NUM_REQ)) u_rr (
    .valid (req_valid),
    .last  (last_grant_r),
    .grant (grant_s),
    .found (found_s),
    .idx   (idx_s)
  );

  HybridAdder u_add (
    .a     (op_a_r),
    .b     (op_b_r),
    .c_in  (op_cin_r),
    .sum   (sum_s),
    .c_out (cout_s)
  );

  // Operand mux for the granted requester (grant is one-hot or zero).
  always_comb begin
    sel_a_s   = 32'd0;
    sel_b_s   = 32'd0;
    sel_sub_s = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_a_s   = sel_a_s | (req_a[i*DATA_W +: DATA_W] & {DATA_W{grant_s[i]}});
      sel_b_s   = sel_b_s | (req_b[i*DATA_W +: DATA_W] & {DATA_W{grant_s[i]}});
      sel_sub_s = sel_sub_s | (req_sub[i] & grant_s[i]);
    end
  end

  // Ready only in IDLE and forced low while reset is held.
  assign req_ready = (rst_n && (state_r == IDLE)) ? grant_s : {NUM_REQ{1'b0}};
  assign rsp_valid = rsp_valid_r;
  assign rsp_sum   = rsp_sum_r;
  assign rsp_cout  = rsp_cout_r;
  assign rsp_id    = rsp_id_r;

  // Grant/execute/respond sequencer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      last_grant_r <= IDX_W'(NUM_REQ - 1);
      op_a_r       <= 32'd0;
      op_b_r       <= 32'd0;
      op_cin_r     <= 1'b0;
      id_r         <= '0;
      rsp_valid_r  <= 1'b0;
      rsp_sum_r    <= 32'd0;
      rsp_cout_r   <= 1'b0;
      rsp_id_r     <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (found_s) begin
            op_a_r       <= sel_a_s;
            op_b_r       <= sel_sub_s ? ~sel_b_s : sel_b_s;
            op_cin_r     <= sel_sub_s;
            id_r         <= ID_W'(idx_s);
            last_grant_r <= idx_s;
            state_r      <= EXEC;
          end
        end
        EXEC: begin
          rsp_sum_r   <= sum_s;
          rsp_cout_r  <= cout_s;
          rsp_id_r    <= id_r;
          rsp_valid_r <= 1'b1;
          state_r     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

`ifdef ADDER_ARB_OVF_EN
  logic rsp_ovf_r;

  assign rsp_ovf = rsp_ovf_r;

  // Signed overflow of the post-inversion operands, captured with the sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_ovf_r <= 1'b0;
    end else if (state_r == EXEC) begin
      rsp_ovf_r <= (op_a_r[31] == op_b_r[31]) && (sum_s[31] != op_a_r[31]);
    end
  end
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed self-checking bench for adder_arbiter (NUM_REQ=2, ID_W=1).
module tb_adder_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ID_W    = 1;

  logic                 clk;
  logic                 rst_n;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*32-1:0] req_a;
  logic [NUM_REQ*32-1:0] req_b;
  logic [NUM_REQ-1:0]   req_sub;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [31:0]          rsp_sum;
  logic                 rsp_cout;
  logic [ID_W-1:0]      rsp_id;
`ifdef ADDER_ARB_OVF_EN
  logic                 rsp_ovf;
`endif

  int checks = 0;
  int errors = 0;

  adder_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sub   (req_sub),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_id    (rsp_id)
`ifdef ADDER_ARB_OVF_EN
    ,.rsp_ovf  (rsp_ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reset and return at posedge+1 with the DUT idle.
  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_sub   = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Single transaction on requester r; collects observed values for the caller.
  task automatic run_op(input int r, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, output logic [1:0] rdy, output logic v_exec,
                        output logic v_rsp, output logic [31:0] sum,
                        output logic cout, output logic [ID_W-1:0] id, output logic ovf);
    req_a[r*32 +: 32] = a;
    req_b[r*32 +: 32] = b;
    req_sub[r]        = sub;
    req_valid[r]      = 1'b1;
    #4 rdy = req_ready;
    @(posedge clk);
    #1 req_valid = '0;
    v_exec = rsp_valid;
    @(posedge clk);
    #1 v_rsp = rsp_valid;
    sum  = rsp_sum;
    cout = rsp_cout;
    id   = rsp_id;
`ifdef ADDER_ARB_OVF_EN
    ovf = rsp_ovf;
`else
    ovf = 1'b0;
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 2'b11;
    req_a     = '0;
    req_b     = '0;
    req_sub   = '0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready got %b want 00", req_ready); end
    checks++;
    if ({rsp_valid, rsp_cout, rsp_id, rsp_sum} !== 35'd0) begin
      errors++; $display("FAIL reset_rsp got v%b c%b id%h s%h want zeros", rsp_valid, rsp_cout, rsp_id, rsp_sum);
    end
    req_valid = '0;
    do_reset();
  endtask

  task automatic test_arith();
    logic [1:0] rdy; logic ve, vr, c, o; logic [31:0] s; logic [ID_W-1:0] id;
    logic [31:0] va [6] = '{32'h5, 32'h3, 32'h5, 32'hFFFF_FFFF, 32'h0, 32'h7FFF_FFFF};
    logic [31:0] vb [6] = '{32'h3, 32'h5, 32'h3, 32'h1,        32'h0, 32'h1};
    logic        vs [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    int          vr_ [6] = '{0, 1, 1, 0, 1, 0};
    logic [31:0] es [6] = '{32'h8, 32'hFFFF_FFFE, 32'h2, 32'h0, 32'h0, 32'h8000_0000};
    logic        ec [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic        eo [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      run_op(vr_[k], va[k], vb[k], vs[k], rdy, ve, vr, s, c, id, o);
      checks++;
      if (rdy !== (2'b01 << vr_[k])) begin errors++; $display("FAIL arith%0d_ready got %b want %b", k, rdy, 2'b01 << vr_[k]); end
      checks++;
      if (ve !== 1'b0 || vr !== 1'b1) begin errors++; $display("FAIL arith%0d_latency got exec%b resp%b want 0 1", k, ve, vr); end
      checks++;
      if (s !== es[k] || c !== ec[k]) begin errors++; $display("FAIL arith%0d_sum got %h/%b want %h/%b", k, s, c, es[k], ec[k]); end
      checks++;
      if (id !== ID_W'(vr_[k])) begin errors++; $display("FAIL arith%0d_id got %0d want %0d", k, id, vr_[k]); end
`ifdef ADDER_ARB_OVF_EN
      checks++;
      if (o !== eo[k]) begin errors++; $display("FAIL arith%0d_ovf got %b want %b", k, o, eo[k]); end
`endif
    end
  endtask

  task automatic test_fairness();
    logic [1:0] exp_rdy;
    int g;
    do_reset();
    req_a     = {32'd20, 32'd10};
    req_b     = {32'd2,  32'd1};
    req_sub   = 2'b00;
    req_valid = 2'b11;
    for (int c = 0; c < 12; c++) begin
      g = (c / 3) % 2;
      exp_rdy = (c % 3 == 0) ? (2'b01 << g) : 2'b00;
      #4;
      checks++;
      if (req_ready !== exp_rdy) begin errors++; $display("FAIL fair_ready c%0d got %b want %b", c, req_ready, exp_rdy); end
      checks++;
      if (rsp_valid !== (c % 3 == 2)) begin errors++; $display("FAIL fair_valid c%0d got %b want %b", c, rsp_valid, (c % 3 == 2)); end
      if (c % 3 == 2) begin
        checks++;
        if (rsp_id !== ID_W'(g) || rsp_sum !== (g == 1 ? 32'd22 : 32'd11)) begin
          errors++; $display("FAIL fair_rsp c%0d got id%0d s%0d want id%0d", c, rsp_id, rsp_sum, g);
        end
      end
      @(posedge clk);
      #1;
    end
    req_valid = '0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    do_reset();
    rsp_ready = 1'b0;
    req_a     = {32'd100, 32'd7};
    req_b     = {32'd1,   32'd9};
    req_sub   = 2'b00;
    req_valid = 2'b01;
    @(posedge clk);
    #1 req_valid = 2'b10;
    @(posedge clk);
    #1;
    for (int c = 0; c < 5; c++) begin
      #4;
      checks++;
      if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_ready c%0d got %b want 00", c, req_ready); end
      checks++;
      if (rsp_valid !== 1'b1 || rsp_sum !== 32'd16 || rsp_id !== 1'b0 || rsp_cout !== 1'b0) begin
        errors++; $display("FAIL bp_hold c%0d got v%b s%0d id%0d want 1 16 0", c, rsp_valid, rsp_sum, rsp_id);
      end
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #5;
    checks++;
    if (req_ready !== 2'b10) begin errors++; $display("FAIL bp_grant1 got %b want 10", req_ready); end
    @(posedge clk);
    #1 req_valid = '0;
    @(posedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_sum !== 32'd101 || rsp_id !== 1'b1) begin
      errors++; $display("FAIL bp_rsp1 got v%b s%0d id%0d want 1 101 1", rsp_valid, rsp_sum, rsp_id);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_midop();
    do_reset();
    req_a     = {32'd4, 32'd1};
    req_b     = {32'd4, 32'd1};
    req_sub   = 2'b00;
    req_valid = 2'b01;
    @(posedge clk);
    #1 req_valid = 2'b10;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_cout, rsp_id, rsp_sum} !== 37'd0) begin
      errors++; $display("FAIL midop_reset got r%b v%b s%h want zeros", req_ready, rsp_valid, rsp_sum);
    end
    @(posedge clk);
    #1 req_valid = '0;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #4;
      checks++;
      if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midop_stale c%0d got %b want 0", c, rsp_valid); end
      @(posedge clk);
      #1;
    end
    req_valid = 2'b11;
    #4;
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL midop_prio got %b want 01", req_ready); end
    @(posedge clk);
    #1 req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_arith();
    test_fairness();
    test_backpressure();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
